shift_seq: RTL and testbench

Multi-cycle shift sequencer for the ALU datapath. It applies the team's single-step shift/rotate operation repeatedly, 0 to 2^CNTW-1 times, under a start/busy/done handshake. Carry is threaded from step to step, so multi-bit shift-through-carry and rotates are exact. It sits beside the combinational single-step shifter and serves multi-bit shift opcodes, which the sequencer stalls on until done.

---
 rtl/shift_seq.sv | 99 +++++++++
 tb/tb_shift_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq.sv
// Multi-cycle shift/rotate sequencer: repeats the single-step shift 'count' times, carry threaded between steps.
// Latency: done pulses count+1 cycles after the cycle start is driven (count=0 -> next cycle).
// Backpressure: start is ignored while busy; start in the done cycle is accepted back-to-back.
module shift_seq #(
    parameter int WIDTH = 8,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             cin,
    input  logic [2:0]       mode,
    input  logic [CNTW-1:0]  count,
    output logic [WIDTH-1:0] dout,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [2:0]       mode_q;
    logic [CNTW-1:0]  remaining;
    logic             nb;
    logic [WIDTH-1:0] step_d;
    logic             step_c;

    // One step of the shared shift op, applied to the current result/carry.
    always_comb begin
        nb     = mode_q[1] ? (mode_q[0] ? dout[WIDTH-1] : dout[0]) : (cout & mode_q[0]);
        step_d = '0;
        step_c = 1'b0;
        if (mode_q[2]) begin
            step_d = {nb, dout[WIDTH-1:1]};
            step_c = dout[0];
        end else begin
            step_d = {dout[WIDTH-2:0], nb};
            step_c = dout[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            dout      <= '0;
            cout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mode_q    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dout      <= din;
                        cout      <= cin;
                        mode_q    <= mode;
                        remaining <= count;
                        if (count != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end
                RUN: begin
                    dout      <= step_d;
                    cout      <= step_c;
                    remaining <= remaining - 1'b1;
                    if (remaining == CNTW'(1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_seq.sv
// Bench for shift_seq: closed-form result model plus cycle checker, and directed literal vectors.
module tb_shift_seq;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] din;
    logic       cin;
    logic [2:0] mode;
    logic [2:0] count;
    logic [7:0] dout;
    logic       cout;
    logic       busy;
    logic       done;

    int checks = 0;
    int passes = 0;

    shift_seq #(.WIDTH(8), .CNTW(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .din   (din),
        .cin   (cin),
        .mode  (mode),
        .count (count),
        .dout  (dout),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Whole-operation result computed in closed form per mode: {carry,data} treated
    // as a 9-bit word shifted or rotated n places at once.
    function automatic logic [8:0] apply_ops(input logic [7:0] d, input logic c,
                                             input logic [2:0] m, input int n);
        logic [8:0] v;
        logic [7:0] r;
        logic [7:0] fill;
        case (m)
            3'b000: begin v = {c, d} << n; return v; end
            3'b001: begin v = {c, d}; v = (v << n) | (v >> (9 - n)); return v; end
            3'b011: begin r = (d << n) | (d >> (8 - n)); return {(n == 0) ? c : r[0], r}; end
            3'b010: begin
                v = {c, d} << n;
                fill = d[0] ? 8'((1 << n) - 1) : 8'h00;
                return {v[8], v[7:0] | fill};
            end
            3'b100: begin v = {d, c} >> n; return {v[0], v[8:1]}; end
            3'b101: begin v = {d, c}; v = (v >> n) | (v << (9 - n)); return {v[0], v[8:1]}; end
            3'b110: begin r = (d >> n) | (d << (8 - n)); return {(n == 0) ? c : r[7], r}; end
            default: begin
                v = {d, c} >> n;
                r = 8'($signed(d) >>> n);
                return {v[0], r};
            end
        endcase
    endfunction

    // Cycle model: steps remaining, done flag, and the final result of the current op.
    int         m_left;
    logic       m_done;
    logic [7:0] m_dout;
    logic       m_cout;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_dout <= 8'h00;
            m_cout <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
        end else if (start) begin
            m_left <= int'(count);
            m_done <= (count == 3'd0);
            {m_cout, m_dout} <= apply_ops(din, cin, mode, int'(count));
        end else begin
            m_done <= 1'b0;
        end
    end

    // Result is only meaningful outside the stepping window.
    always @(negedge clk) begin
        chk("model_busy", 32'(busy), 32'(m_left > 0));
        chk("model_done", 32'(done), 32'(m_done));
        if (m_left == 0) begin
            chk("model_dout", 32'(dout), 32'(m_dout));
            chk("model_cout", 32'(cout), 32'(m_cout));
        end
    end

    task automatic launch(input logic [7:0] d, input logic c, input logic [2:0] m, input logic [2:0] n);
        start = 1'b1;
        din   = d;
        cin   = c;
        mode  = m;
        count = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        din   = 8'h5A;
        cin   = ~c;
        mode  = ~m;
        count = ~n;
    endtask

    // Runs one op; 'now' launches in the current cycle (e.g. a done cycle) instead of the next.
    task automatic do_op(input string name, input bit now, input logic [7:0] d, input logic c,
                         input logic [2:0] m, input logic [2:0] n,
                         input logic [7:0] ed, input logic ec);
        int lat;
        int bz;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        launch(d, c, m, n);
        lat = 1;
        bz  = busy ? 1 : 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) bz++;
        end
        chk({name, "_done_seen"}, 32'(done), 32'd1);
        chk({name, "_latency"}, 32'(lat), 32'(n) + 32'd1);
        chk({name, "_busy_cycles"}, 32'(bz), 32'(n));
        chk({name, "_dout"}, 32'(dout), 32'(ed));
        chk({name, "_cout"}, 32'(cout), 32'(ec));
    endtask

    initial begin
        int lat;
        rst_n = 1'b0;
        start = 1'b0;
        din   = 8'h00;
        cin   = 1'b0;
        mode  = 3'b000;
        count = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_dout", 32'(dout), 32'h00);
        chk("reset_cout", 32'(cout), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_done", 32'(done), 32'h0);
        rst_n = 1'b1;

        do_op("rotl3",  0, 8'h96, 1'b0, 3'b011, 3'd3, 8'hB4, 1'b0);
        do_op("asr2",   0, 8'h96, 1'b0, 3'b111, 3'd2, 8'hE5, 1'b1);
        do_op("rrc2",   0, 8'h96, 1'b1, 3'b101, 3'd2, 8'h65, 1'b1);
        do_op("lsr2",   0, 8'h96, 1'b1, 3'b100, 3'd2, 8'h25, 1'b1);
        do_op("lsl0",   0, 8'h96, 1'b1, 3'b000, 3'd0, 8'h96, 1'b1);
        do_op("lsl1",   0, 8'h96, 1'b1, 3'b000, 3'd1, 8'h2C, 1'b1);
        do_op("lslrep3",0, 8'h35, 1'b0, 3'b010, 3'd3, 8'hAF, 1'b1);
        do_op("rotr3",  0, 8'h96, 1'b0, 3'b110, 3'd3, 8'hD2, 1'b1);
        do_op("rlc7",   0, 8'h96, 1'b0, 3'b001, 3'd7, 8'h25, 1'b1);
        // Back-to-back: new start driven in the done cycle of the previous op.
        do_op("b2b",    1, 8'h96, 1'b0, 3'b111, 3'd2, 8'hE5, 1'b1);
        do_op("b2b0",   1, 8'h3C, 1'b0, 3'b110, 3'd0, 8'h3C, 1'b0);

        // start pulsed mid-run with a different operand must be ignored.
        @(posedge clk);
        #1;
        launch(8'h96, 1'b0, 3'b011, 3'd7);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        din   = 8'hFF;
        mode  = 3'b100;
        count = 3'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("ignore_start_done", 32'(done), 32'd1);
        chk("ignore_start_dout", 32'(dout), 32'h4B);
        chk("ignore_start_cout", 32'(cout), 32'h1);

        // Asynchronous reset in the middle of a count=7 run.
        @(posedge clk);
        #1;
        launch(8'h96, 1'b1, 3'b101, 3'd7);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dout", 32'(dout), 32'h00);
        chk("arst_cout", 32'(cout), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_done", 32'(done), 32'h0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        do_op("post_rst", 0, 8'h96, 1'b0, 3'b111, 3'd7, 8'hFF, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
